// File: rtl/seg_scan_ctrl_if.sv
// Load port for seg_scan_ctrl: valid/ready transfer of a 24-bit display value
// (six hex nibbles, nibble 0 = rightmost digit on CS[0]).
interface seg_scan_ctrl_if;
  logic        LOAD_VALID;
  logic        LOAD_READY;
  logic [23:0] LOAD_DATA;

  modport master (output LOAD_VALID, output LOAD_DATA, input LOAD_READY);
  modport slave  (input LOAD_VALID, input LOAD_DATA, output LOAD_READY);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Six-digit 7-segment scan scheduler. Each digit slot is SCAN_DIV cycles: the
// first BLANK_CYC cycles drive everything off (anti-ghosting), the rest light
// one digit. New values land in a shadow register and are swapped into the
// active register only at frame boundaries, so a frame never tears.
// Optional build macro SEG_LZ_BLANK_EN: leading-zero blanking on digits 1..5.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  seg_scan_ctrl_if.slave   load,
  output logic [6:0]       DB,
  output logic [5:0]       CS,
  output logic             FRAME_DONE
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT_END  = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [23:0]      active;
  logic [23:0]      shadow;
  logic             ready_q;
  logic             accept;
  logic             frame_end;
  logic [6:0]       db_nxt;
  logic [5:0]       cs_nxt;
  logic             fd_nxt;

  // Hex digit to active-low segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Nibble for a digit position; positions 6/7 never occur
  function automatic logic [3:0] nib_sel(input logic [23:0] val, input logic [2:0] dig);
    logic [3:0] nib;
    case (dig)
      3'd0:    nib = val[3:0];
      3'd1:    nib = val[7:4];
      3'd2:    nib = val[11:8];
      3'd3:    nib = val[15:12];
      3'd4:    nib = val[19:16];
      default: nib = val[23:20];
    endcase
    return nib;
  endfunction

`ifdef SEG_LZ_BLANK_EN
  // True when the digit and every more-significant digit are zero; digit 0 stays lit
  function automatic logic lz_blank(input logic [23:0] val, input logic [2:0] dig);
    logic zero;
    zero = (dig != 3'd0);
    for (int i = 1; i < 6; i++) begin
      if (i >= int'(dig) && val[4*i +: 4] != 4'h0) zero = 1'b0;
    end
    return zero;
  endfunction
`endif

  assign accept          = load.LOAD_VALID & ready_q;
  assign load.LOAD_READY = ready_q;
  assign frame_end       = ENABLE && (state == SHOW) && (idx == 3'd5) && (cnt == CNT_SLOT_END);

  // FSM state register with slot counter and digit index
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic: blank gap, then lit digit, then advance to the next slot
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    if (!ENABLE) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
        BLANK: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_BLANK_END) state_nxt = SHOW;
        end
        SHOW: begin
          if (cnt == CNT_SLOT_END) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            idx_nxt   = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so registered outputs line up with it
  always_comb begin
    db_nxt = 7'h7F;
    cs_nxt = 6'h3F;
    fd_nxt = 1'b0;
    if (state_nxt == SHOW) begin
      cs_nxt = ~(6'b000001 << idx_nxt);
`ifdef SEG_LZ_BLANK_EN
      db_nxt = lz_blank(active, idx_nxt) ? 7'h7F : seg_decode(nib_sel(active, idx_nxt));
`else
      db_nxt = seg_decode(nib_sel(active, idx_nxt));
`endif
      fd_nxt = (idx_nxt == 3'd5) && (cnt_nxt == CNT_SLOT_END);
    end
  end

  // Output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DB         <= 7'h7F;
      CS         <= 6'h3F;
      FRAME_DONE <= 1'b0;
    end else begin
      DB         <= db_nxt;
      CS         <= cs_nxt;
      FRAME_DONE <= fd_nxt;
    end
  end

  // Shadow load and frame-boundary swap; an accept and a swap never coincide
  // because accept needs an empty shadow and swap needs a full one
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      active  <= '0;
      shadow  <= '0;
      ready_q <= 1'b1;
    end else if (accept) begin
      shadow  <= load.LOAD_DATA;
      ready_q <= 1'b0;
    end else if (!ready_q && (frame_end || state == IDLE)) begin
      active  <= shadow;
      ready_q <= 1'b1;
    end
  end

endmodule
